// File: rtl/sync_addr_cam_pkg.sv
// Shared definitions for the synchronous address CAM.
//
// Contents:
//   OP_READ .. OP_FLUSH : request opcode encodings carried on req_op (3 bits).
//                         Codes 6 and 7 are reserved.
//   cam_state_t         : controller state. IDLE accepts requests.
//                         INS_ALLOC is the second cycle of an INSERT.
package sync_addr_cam_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_READ   = 3'd0;
  localparam logic [OP_W-1:0] OP_WRITE  = 3'd1;
  localparam logic [OP_W-1:0] OP_SEARCH = 3'd2;
  localparam logic [OP_W-1:0] OP_INSERT = 3'd3;
  localparam logic [OP_W-1:0] OP_INVAL  = 3'd4;
  localparam logic [OP_W-1:0] OP_FLUSH  = 3'd5;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    INS_ALLOC = 1'b1
  } cam_state_t;

endpackage

// File: rtl/sync_addr_cam_lsb_prio_enc.sv
// Lowest-set-bit priority encoder.
//
// Ports:
//   vec : input request vector, one bit per CAM entry
//   idx : index of the lowest set bit of vec (0 when vec is all zero)
//   any : 1 when at least one bit of vec is set
//
// The CAM uses one instance on the match vector and another on the inverted
// valid vector. The first gives the lowest matching entry. The second gives
// the lowest free entry.
module lsb_prio_enc
  import sync_addr_cam_pkg::*;
#(
  parameter int ROW_NUM     = 68,
  parameter int ENTRY_WIDTH = 7
) (
  input  logic [ROW_NUM-1:0]     vec,
  output logic [ENTRY_WIDTH-1:0] idx,
  output logic                   any
);

  // Scan from the top down so that the last assignment, which wins, comes
  // from the lowest set bit.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = ROW_NUM - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ENTRY_WIDTH'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_addr_cam.sv
// Clocked address CAM with ROW_NUM entries of WORD_SIZE-bit keys. Each entry
// has its own valid bit.
//
// Supported operations: read, write, search, invalidate, flush, and an atomic
// search-or-insert. On a miss, the insert allocates the lowest free entry.
//
// Ports:
//   clk, reset          : single clock. Reset is synchronous and active high.
//   req_valid/req_ready : request handshake (see below).
//   req_op              : operation, using the OP_* codes from sync_addr_cam_pkg.
//   req_addr            : entry index for READ, WRITE and INVAL.
//   req_data            : key for WRITE, SEARCH and INSERT.
//   resp_valid          : one-cycle pulse. While it is high, resp_* are valid.
//   resp_hit            : match found, or the addressed entry was valid.
//   resp_multi          : more than one valid entry matched.
//   resp_full           : INSERT missed and no free entry was available.
//   resp_addr           : matched, allocated or addressed index.
//   resp_data           : stored key (READ) or echoed key (SEARCH/INSERT).
//   valid_count         : number of valid entries.
//   full                : valid_count == ROW_NUM.
//
// Handshake: a request is taken on a rising clk edge where
// req_valid & req_ready are both 1. req_ready is high only in IDLE and only
// outside reset. A requester holds req_* stable until that edge. After an
// accepted INSERT, req_ready drops for exactly one cycle. No request can land
// while the allocation is pending, so the match and free vectors captured at
// acceptance are still exact when the write is committed.
//
// Response timing:
//   - READ, WRITE, SEARCH, INVAL and FLUSH respond on the cycle after
//     acceptance.
//   - INSERT responds on the cycle after INS_ALLOC.
//   - Reserved opcodes are consumed silently.
module sync_addr_cam
  import sync_addr_cam_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int ROW_NUM     = 68,
  parameter int ENTRY_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [OP_W-1:0]        req_op,
  input  logic [ENTRY_WIDTH-1:0] req_addr,
  input  logic [WORD_SIZE-1:0]   req_data,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic                   resp_multi,
  output logic                   resp_full,
  output logic [ENTRY_WIDTH-1:0] resp_addr,
  output logic [WORD_SIZE-1:0]   resp_data,
  output logic [ENTRY_WIDTH:0]   valid_count,
  output logic                   full
);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [ROW_NUM-1:0]   valid;
  logic [WORD_SIZE-1:0] keys [ROW_NUM];

  cam_state_t state;

  // Values captured when an INSERT is accepted. They are committed in
  // INS_ALLOC.
  logic [WORD_SIZE-1:0]   ins_key;
  logic                   ins_hit;
  logic                   ins_multi;
  logic [ENTRY_WIDTH-1:0] ins_match_idx;
  logic                   ins_free_any;
  logic [ENTRY_WIDTH-1:0] ins_free_idx;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic                   accept;
  logic                   addr_ok;
  logic [ENTRY_WIDTH-1:0] addr_sel;
  logic                   addr_valid;
  logic [WORD_SIZE-1:0]   addr_key;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Out-of-range addresses are steered to entry 0. addr_ok then masks every
  // effect, so no array is ever indexed past ROW_NUM-1.
  assign addr_ok    = (32'(req_addr) < 32'(ROW_NUM));
  assign addr_sel   = addr_ok ? req_addr : '0;
  assign addr_valid = addr_ok && valid[addr_sel];
  assign addr_key   = keys[addr_sel];

  // ---------------------------------------------------------------------------
  // Associative compare against registered state
  // ---------------------------------------------------------------------------
  logic [ROW_NUM-1:0]     match_vec;
  logic [ROW_NUM-1:0]     free_vec;
  logic [ENTRY_WIDTH-1:0] match_idx;
  logic                   match_any;
  logic [ENTRY_WIDTH-1:0] free_idx;
  logic                   free_any;
  logic                   match_multi;

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < ROW_NUM; i++) begin
      match_vec[i] = valid[i] && (keys[i] == req_data);
    end
  end

  assign free_vec = ~valid;

  // v & (v - 1) clears the lowest set bit. Anything left means at least two
  // entries matched.
  assign match_multi = |(match_vec & (match_vec - ROW_NUM'(1)));

  lsb_prio_enc #(
    .ROW_NUM     (ROW_NUM),
    .ENTRY_WIDTH (ENTRY_WIDTH)
  ) u_match_enc (
    .vec (match_vec),
    .idx (match_idx),
    .any (match_any)
  );

  lsb_prio_enc #(
    .ROW_NUM     (ROW_NUM),
    .ENTRY_WIDTH (ENTRY_WIDTH)
  ) u_free_enc (
    .vec (free_vec),
    .idx (free_idx),
    .any (free_any)
  );

  assign full = (valid_count == (ENTRY_WIDTH+1)'(ROW_NUM));

  // ---------------------------------------------------------------------------
  // Key storage. It has no reset because contents are qualified by valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept && (req_op == OP_WRITE) && addr_ok) begin
        keys[addr_sel] <= req_data;
      end else if ((state == INS_ALLOC) && !ins_hit && ins_free_any) begin
        keys[ins_free_idx] <= ins_key;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Controller: valid bits, count, FSM and registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset during INS_ALLOC lands here too, which drops the pending insert.
      state         <= IDLE;
      valid         <= '0;
      valid_count   <= '0;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_multi    <= 1'b0;
      resp_full     <= 1'b0;
      resp_addr     <= '0;
      resp_data     <= '0;
      ins_key       <= '0;
      ins_hit       <= 1'b0;
      ins_multi     <= 1'b0;
      ins_match_idx <= '0;
      ins_free_any  <= 1'b0;
      ins_free_idx  <= '0;
    end else begin
      resp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            case (req_op)
              OP_READ: begin
                resp_valid <= 1'b1;
                resp_hit   <= addr_valid;
                resp_multi <= 1'b0;
                resp_full  <= 1'b0;
                resp_addr  <= req_addr;
                resp_data  <= addr_valid ? addr_key : '0;
              end

              OP_WRITE: begin
                // No duplicate check. The same key may live in several entries.
                if (addr_ok) begin
                  valid[addr_sel] <= 1'b1;
                  if (!valid[addr_sel]) begin
                    valid_count <= valid_count + (ENTRY_WIDTH+1)'(1);
                  end
                end
                resp_valid <= 1'b1;
                resp_hit   <= addr_valid;
                resp_multi <= 1'b0;
                resp_full  <= 1'b0;
                resp_addr  <= req_addr;
                resp_data  <= '0;
              end

              OP_SEARCH: begin
                resp_valid <= 1'b1;
                resp_hit   <= match_any;
                resp_multi <= match_multi;
                resp_full  <= 1'b0;
                resp_addr  <= match_any ? match_idx : '0;
                resp_data  <= req_data;
              end

              OP_INSERT: begin
                ins_key       <= req_data;
                ins_hit       <= match_any;
                ins_multi     <= match_multi;
                ins_match_idx <= match_idx;
                ins_free_any  <= free_any;
                ins_free_idx  <= free_idx;
                state         <= INS_ALLOC;
              end

              OP_INVAL: begin
                if (addr_valid) begin
                  valid[addr_sel] <= 1'b0;
                  valid_count     <= valid_count - (ENTRY_WIDTH+1)'(1);
                end
                resp_valid <= 1'b1;
                resp_hit   <= addr_valid;
                resp_multi <= 1'b0;
                resp_full  <= 1'b0;
                resp_addr  <= req_addr;
                resp_data  <= '0;
              end

              OP_FLUSH: begin
                valid       <= '0;
                valid_count <= '0;
                resp_valid  <= 1'b1;
                resp_hit    <= 1'b0;
                resp_multi  <= 1'b0;
                resp_full   <= 1'b0;
                resp_addr   <= '0;
                resp_data   <= '0;
              end

              default: begin
                // Reserved opcode: the request is consumed with no effect.
              end
            endcase
          end
        end

        INS_ALLOC: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          resp_data  <= ins_key;
          if (ins_hit) begin
            resp_hit   <= 1'b1;
            resp_multi <= ins_multi;
            resp_full  <= 1'b0;
            resp_addr  <= ins_match_idx;
          end else if (ins_free_any) begin
            valid[ins_free_idx] <= 1'b1;
            valid_count         <= valid_count + (ENTRY_WIDTH+1)'(1);
            resp_hit            <= 1'b0;
            resp_multi          <= 1'b0;
            resp_full           <= 1'b0;
            resp_addr           <= ins_free_idx;
          end else begin
            resp_hit   <= 1'b0;
            resp_multi <= 1'b0;
            resp_full  <= 1'b1;
            resp_addr  <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_addr_cam.sv
// Bench for sync_addr_cam, built with 6 entries and a 3-bit index. Index 7
// is therefore out of range, and the insert sequence can fill the table.
module tb_sync_addr_cam;
  import sync_addr_cam_pkg::*;

  localparam int WS = 16;
  localparam int RN = 6;
  localparam int EW = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [EW-1:0] req_addr;
  logic [WS-1:0] req_data;
  logic          resp_valid;
  logic          resp_hit;
  logic          resp_multi;
  logic          resp_full;
  logic [EW-1:0] resp_addr;
  logic [WS-1:0] resp_data;
  logic [EW:0]   valid_count;
  logic          full;

  always #5 clk = ~clk;

  sync_addr_cam #(
    .WORD_SIZE   (WS),
    .ROW_NUM     (RN),
    .ENTRY_WIDTH (EW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_multi  (resp_multi),
    .resp_full   (resp_full),
    .resp_addr   (resp_addr),
    .resp_data   (resp_data),
    .valid_count (valid_count),
    .full        (full)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, required end before 1ms");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  typedef struct packed {
    logic          has_resp;
    logic          hit;
    logic          multi;
    logic          full;
    logic [EW-1:0] addr;
    logic [WS-1:0] data;
  } exp_t;

  typedef struct packed {
    logic [2:0]    op;
    logic [EW-1:0] addr;
    logic [WS-1:0] data;
    exp_t          e;
    int            cnt;
  } vec_t;

  // ---------------------------------------------------------------------------
  // Reference model: a plain key table with valid flags
  // ---------------------------------------------------------------------------
  logic [WS-1:0] m_key   [RN];
  bit            m_valid [RN];

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < RN; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  function automatic exp_t model_apply(input logic [2:0] op, input logic [EW-1:0] addr,
                                       input logic [WS-1:0] data);
    exp_t e;
    bit   in_range;
    int   nmatch;
    int   first;
    int   freeidx;
    e        = '0;
    e.has_resp = 1'b1;
    in_range = (int'(addr) < RN);
    nmatch   = 0;
    first    = -1;
    freeidx  = -1;
    for (int i = 0; i < RN; i++) begin
      if (m_valid[i] && m_key[i] == data) begin
        if (first < 0) first = i;
        nmatch++;
      end
      if (!m_valid[i] && freeidx < 0) freeidx = i;
    end
    case (op)
      OP_READ: begin
        if (in_range) e.hit = m_valid[addr];
        e.addr = addr;
        e.data = e.hit ? m_key[addr] : '0;
      end
      OP_WRITE: begin
        if (in_range) begin
          e.hit         = m_valid[addr];
          m_key[addr]   = data;
          m_valid[addr] = 1'b1;
        end
        e.addr = addr;
      end
      OP_SEARCH: begin
        e.hit   = (nmatch > 0);
        e.multi = (nmatch > 1);
        e.addr  = (first < 0) ? '0 : EW'(first);
        e.data  = data;
      end
      OP_INSERT: begin
        e.data = data;
        if (nmatch > 0) begin
          e.hit   = 1'b1;
          e.multi = (nmatch > 1);
          e.addr  = EW'(first);
        end else if (freeidx >= 0) begin
          e.addr           = EW'(freeidx);
          m_key[freeidx]   = data;
          m_valid[freeidx] = 1'b1;
        end else begin
          e.full = 1'b1;
        end
      end
      OP_INVAL: begin
        if (in_range) begin
          e.hit         = m_valid[addr];
          m_valid[addr] = 1'b0;
        end
        e.addr = addr;
      end
      OP_FLUSH: begin
        for (int i = 0; i < RN; i++) m_valid[i] = 1'b0;
      end
      default: e.has_resp = 1'b0;
    endcase
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: called at a negedge, returns at a negedge
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [2:0] op, input logic [EW-1:0] addr, input logic [WS-1:0] data,
                       output exp_t act, output logic ready_after, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    @(posedge clk);
    @(negedge clk);
    req_valid   = 1'b0;
    ready_after = req_ready;
    act         = '0;
    lat         = 0;
    for (int k = 1; k <= 4; k++) begin
      if (resp_valid) begin
        act.has_resp = 1'b1;
        act.hit      = resp_hit;
        act.multi    = resp_multi;
        act.full     = resp_full;
        act.addr     = resp_addr;
        act.data     = resp_data;
        lat          = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_check(input string tag, input logic [2:0] op, input logic [EW-1:0] addr,
                           input logic [WS-1:0] data, input exp_t e, input int cnt);
    exp_t a;
    logic rdy;
    int   lat;
    issue(op, addr, data, a, rdy, lat);
    chk({tag, ".resp_valid"}, 32'(a.has_resp), 32'(e.has_resp));
    if (e.has_resp && a.has_resp) begin
      chk({tag, ".latency"}, 32'(lat), (op == OP_INSERT) ? 32'd2 : 32'd1);
      chk({tag, ".resp_hit"}, 32'(a.hit), 32'(e.hit));
      chk({tag, ".resp_multi"}, 32'(a.multi), 32'(e.multi));
      chk({tag, ".resp_full"}, 32'(a.full), 32'(e.full));
      if (op != OP_FLUSH) chk({tag, ".resp_addr"}, 32'(a.addr), 32'(e.addr));
      if (op inside {OP_READ, OP_SEARCH, OP_INSERT})
        chk({tag, ".resp_data"}, 32'(a.data), 32'(e.data));
    end
    chk({tag, ".ready_after_accept"}, 32'(rdy), (op == OP_INSERT) ? 32'd0 : 32'd1);
    chk({tag, ".valid_count"}, 32'(valid_count), 32'(cnt));
    chk({tag, ".full"}, 32'(full), (cnt == RN) ? 32'd1 : 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------------------
  vec_t tbl[$];

  function automatic void add(input logic [2:0] op, input int addr, input int data,
                              input bit hr, input bit hit, input bit multi, input bit fl,
                              input int raddr, input int rdata, input int cnt);
    vec_t v;
    v.op         = op;
    v.addr       = EW'(addr);
    v.data       = WS'(data);
    v.e.has_resp = hr;
    v.e.hit      = hit;
    v.e.multi    = multi;
    v.e.full     = fl;
    v.e.addr     = EW'(raddr);
    v.e.data     = WS'(rdata);
    v.cnt        = cnt;
    tbl.push_back(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    logic [2:0] op;
    int   r;
    bit   seen;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < RN; i++) begin
      m_valid[i] = 1'b0;
      m_key[i]   = '0;
    end

    repeat (3) @(negedge clk);
    chk("ready_during_reset", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.resp_valid", 32'(resp_valid), 32'd0);
    chk("reset.resp_hit", 32'(resp_hit), 32'd0);
    chk("reset.resp_full", 32'(resp_full), 32'd0);
    chk("reset.valid_count", 32'(valid_count), 32'd0);
    chk("reset.full", 32'(full), 32'd0);
    @(negedge clk);

    //  op         addr data     resp hit multi full raddr rdata   cnt
    add(OP_WRITE,  3, 'hBEEF, 1, 0, 0, 0, 3, 0,      1);
    add(OP_SEARCH, 0, 'hBEEF, 1, 1, 0, 0, 3, 'hBEEF, 1);
    add(OP_WRITE,  5, 'h0011, 1, 0, 0, 0, 5, 0,      2);
    add(OP_WRITE,  2, 'h0011, 1, 0, 0, 0, 2, 0,      3);
    add(OP_SEARCH, 0, 'h0011, 1, 1, 1, 0, 2, 'h0011, 3);
    add(OP_INVAL,  2, 0,      1, 1, 0, 0, 2, 0,      2);
    add(OP_SEARCH, 0, 'h0011, 1, 1, 0, 0, 5, 'h0011, 2);
    add(OP_READ,   7, 0,      1, 0, 0, 0, 7, 0,      2);
    add(OP_WRITE,  7, 'h1234, 1, 0, 0, 0, 7, 0,      2);
    add(OP_SEARCH, 0, 'h1234, 1, 0, 0, 0, 0, 'h1234, 2);
    add(OP_READ,   5, 0,      1, 1, 0, 0, 5, 'h0011, 2);
    add(3'd6,      1, 'h0011, 0, 0, 0, 0, 0, 0,      2);
    add(3'd7,      3, 'h0022, 0, 0, 0, 0, 0, 0,      2);
    add(OP_WRITE,  0, 'h0042, 1, 0, 0, 0, 0, 0,      3);
    add(OP_FLUSH,  0, 0,      1, 0, 0, 0, 0, 0,      0);
    add(OP_READ,   0, 0,      1, 0, 0, 0, 0, 0,      0);
    add(OP_READ,   3, 0,      1, 0, 0, 0, 3, 0,      0);
    add(OP_READ,   5, 0,      1, 0, 0, 0, 5, 0,      0);
    add(OP_INSERT, 0, 'h000A, 1, 0, 0, 0, 0, 'h000A, 1);
    add(OP_INSERT, 0, 'h000B, 1, 0, 0, 0, 1, 'h000B, 2);
    add(OP_INSERT, 0, 'h000C, 1, 0, 0, 0, 2, 'h000C, 3);
    add(OP_INSERT, 0, 'h000D, 1, 0, 0, 0, 3, 'h000D, 4);
    add(OP_INSERT, 0, 'h000E, 1, 0, 0, 0, 4, 'h000E, 5);
    add(OP_INSERT, 0, 'h000F, 1, 0, 0, 0, 5, 'h000F, 6);
    add(OP_INSERT, 0, 'h0007, 1, 0, 0, 1, 0, 'h0007, 6);
    add(OP_INSERT, 0, 'h000B, 1, 1, 0, 0, 1, 'h000B, 6);
    add(OP_WRITE,  4, 'h000B, 1, 1, 0, 0, 4, 0,      6);
    add(OP_INSERT, 0, 'h000B, 1, 1, 1, 0, 1, 'h000B, 6);
    add(OP_INVAL,  2, 0,      1, 1, 0, 0, 2, 0,      5);
    add(OP_INSERT, 0, 'h0077, 1, 0, 0, 0, 2, 'h0077, 6);
    add(OP_INVAL,  6, 0,      1, 0, 0, 0, 6, 0,      6);
    add(OP_READ,   2, 0,      1, 1, 0, 0, 2, 'h0077, 6);
    add(OP_FLUSH,  0, 0,      1, 0, 0, 0, 0, 0,      0);

    foreach (tbl[i]) begin
      run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].e, tbl[i].cnt);
      void'(model_apply(tbl[i].op, tbl[i].addr, tbl[i].data));
    end

    // A reset in INS_ALLOC must drop the insert: no write and no response.
    req_valid = 1'b1;
    req_op    = OP_INSERT;
    req_addr  = '0;
    req_data  = 16'h0055;
    @(posedge clk);
    @(negedge clk);
    chk("abort.ready_in_alloc", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort.no_response", 32'(seen), 32'd0);
    chk("abort.valid_count", 32'(valid_count), 32'd0);
    for (int i = 0; i < RN; i++) m_valid[i] = 1'b0;
    e = model_apply(OP_SEARCH, '0, 16'h0055);
    run_check("abort.search55", OP_SEARCH, '0, 16'h0055, e, m_count());

    // Randomized traffic against the model. A small key pool makes hits and
    // multi-matches frequent.
    for (int n = 0; n < 400; n++) begin
      logic [EW-1:0] a;
      logic [WS-1:0] d;
      r = $urandom_range(0, 19);
      if (r < 4)       op = OP_READ;
      else if (r < 9)  op = OP_WRITE;
      else if (r < 12) op = OP_SEARCH;
      else if (r < 16) op = OP_INSERT;
      else if (r < 18) op = OP_INVAL;
      else if (r < 19) op = OP_FLUSH;
      else             op = 3'(6 + $urandom_range(0, 1));
      a = EW'($urandom_range(0, 7));
      d = WS'(16'h00A0 + $urandom_range(0, 5));
      e = model_apply(op, a, d);
      run_check($sformatf("rand%0d", n), op, a, d, e, m_count());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
